// File: rtl/jogo_pkg.sv
// jogo_pkg: definitions shared by the invader game blocks (enemy formation,
// renderer, shot logic).
//   COORD_W          width of one screen coordinate
//   N_INIMIGOS       number of enemies in the formation
//   LARGURA/ALTURA   enemy hit box (11x8 sprite drawn at 3x)
//   estado_t         formation controller FSM encoding
//   empacota_x/y     build the packed per-enemy coordinate buses
package jogo_pkg;

  localparam int COORD_W         = 10;
  localparam int POS_W           = COORD_W + 1;
  localparam int N_INIMIGOS      = 5;
  localparam int LARGURA_INIMIGO = 33;
  localparam int ALTURA_INIMIGO  = 24;

  typedef enum logic [1:0] {
    PARADO  = 2'd0,
    MOVENDO = 2'd1,
    FIM     = 2'd2
  } estado_t;

  // Enemy i sits at bx + i*espaco; the sum is taken at POS_W bits and then
  // cut down to the screen coordinate width.
  function automatic logic [N_INIMIGOS*COORD_W-1:0] empacota_x(
    input logic [POS_W-1:0] bx,
    input int               espaco
  );
    logic [N_INIMIGOS*COORD_W-1:0] r;
    r = '0;
    for (int i = 0; i < N_INIMIGOS; i++) begin
      r[COORD_W*i +: COORD_W] = COORD_W'(bx + POS_W'(i * espaco));
    end
    return r;
  endfunction

  // The whole formation shares one row.
  function automatic logic [N_INIMIGOS*COORD_W-1:0] empacota_y(
    input logic [POS_W-1:0] by
  );
    return {N_INIMIGOS{by[COORD_W-1:0]}};
  endfunction

endpackage

// File: rtl/divisor_tick.sv
// divisor_tick: movement step divider for the enemy formation.
//   CLOCK_50  system clock
//   reset     asynchronous, active-high reset
//   habilita  count enable; while low the counter is held at zero
//   tick      high for the single cycle in which the counter sits at
//             TICK_DIV-1 (counter wraps to zero on that edge)
module divisor_tick #(
  parameter int TICK_DIV = 1_000_000
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic habilita,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] contador;

  assign tick = habilita && (contador == CNT_W'(TICK_DIV - 1));

  // Clearing whenever disabled means a fresh enable always waits a full
  // TICK_DIV cycles before the first step.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      contador <= '0;
    end else if (!habilita || tick) begin
      contador <= '0;
    end else begin
      contador <= contador + 1'b1;
    end
  end

endmodule

// File: rtl/formacao_inimigos.sv
// formacao_inimigos: enemy formation controller, feeding the renderer.
//   CLOCK_50            system clock
//   reset               asynchronous, active-high reset
//   ativo               game running; low freezes formation and step divider
//   x/y_bola_aliada     allied shot position (game coordinates)
//   bola_aliada_ativa   allied shot in flight
//   inimigo_x/y         packed enemy coordinates, enemy i at [10i+9:10i]
//   inimigo_vivo_array  element i high = enemy i alive
//   acerto              one-cycle pulse when an enemy is killed
//   indice_acerto       index of the enemy killed by the last acerto
//   todos_mortos        level: no enemy alive
//   chegou_base         level: formation row reached Y_LIMITE
module formacao_inimigos
  import jogo_pkg::*;
#(
  parameter int TICK_DIV  = 1_000_000,
  parameter int PASSO_X   = 4,
  parameter int PASSO_Y   = 16,
  parameter int X_INICIAL = 40,
  parameter int Y_INICIAL = 40,
  parameter int ESPACO    = 80,
  parameter int X_MAX     = 640,
  parameter int Y_LIMITE  = 400
) (
  input  logic                          CLOCK_50,
  input  logic                          reset,
  input  logic                          ativo,
  input  logic [COORD_W-1:0]            x_bola_aliada,
  input  logic [COORD_W-1:0]            y_bola_aliada,
  input  logic                          bola_aliada_ativa,
  output logic [N_INIMIGOS*COORD_W-1:0] inimigo_x,
  output logic [N_INIMIGOS*COORD_W-1:0] inimigo_y,
  output logic [0:N_INIMIGOS-1]         inimigo_vivo_array,
  output logic                          acerto,
  output logic [2:0]                    indice_acerto,
  output logic                          todos_mortos,
  output logic                          chegou_base
);

  localparam logic [POS_W-1:0] PX   = POS_W'(PASSO_X);
  localparam logic [POS_W-1:0] PY   = POS_W'(PASSO_Y);
  localparam logic [POS_W-1:0] XI   = POS_W'(X_INICIAL);
  localparam logic [POS_W-1:0] YI   = POS_W'(Y_INICIAL);
  localparam logic [POS_W-1:0] XM   = POS_W'(X_MAX);
  localparam logic [POS_W-1:0] YL   = POS_W'(Y_LIMITE);
  localparam logic [POS_W-1:0] LARG = POS_W'(LARGURA_INIMIGO);
  localparam logic [POS_W-1:0] ALT  = POS_W'(ALTURA_INIMIGO);

  estado_t               estado;
  estado_t               proximo;
  logic [POS_W-1:0]      base_x;
  logic [POS_W-1:0]      base_y;
  logic                  dir;
  logic [N_INIMIGOS-1:0] vivo;
  logic [POS_W-1:0]      base_x_prox;
  logic [POS_W-1:0]      base_y_prox;
  logic                  dir_prox;
  logic [N_INIMIGOS-1:0] vivo_prox;

  logic                  habilita;
  logic                  tick;
  logic [POS_W-1:0]      pos_x [N_INIMIGOS];
  logic [POS_W-1:0]      x_dir_max;
  logic [POS_W-1:0]      x_esq_min;
  logic                  na_borda;
  logic [POS_W-1:0]      xb;
  logic [POS_W-1:0]      yb;
  logic                  linha_ok;
  logic [N_INIMIGOS-1:0] atingido;
  logic                  mata;
  logic [2:0]            mata_idx;

  assign habilita = (estado == MOVENDO) && ativo;

  divisor_tick #(
    .TICK_DIV (TICK_DIV)
  ) u_divisor (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .habilita (habilita),
    .tick     (tick)
  );

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      estado <= PARADO;
    end else begin
      estado <= proximo;
    end
  end

  // The end flags are registered, so FIM is entered the cycle after they rise.
  always_comb begin
    proximo = estado;
    case (estado)
      PARADO:  if (ativo) proximo = MOVENDO;
      MOVENDO: begin
        if (todos_mortos || chegou_base) begin
          proximo = FIM;
        end else if (!ativo) begin
          proximo = PARADO;
        end
      end
      FIM:     proximo = FIM;
      default: proximo = PARADO;
    endcase
  end

  always_comb begin
    for (int i = 0; i < N_INIMIGOS; i++) begin
      pos_x[i] = base_x + POS_W'(i * ESPACO);
    end
  end

  // Only living enemies bound the march; the last assignment in each loop
  // wins, giving the rightmost and leftmost alive enemy respectively.
  always_comb begin
    x_dir_max = base_x;
    x_esq_min = base_x;
    for (int i = 0; i < N_INIMIGOS; i++) begin
      if (vivo[i]) x_dir_max = pos_x[i];
    end
    for (int i = N_INIMIGOS - 1; i >= 0; i--) begin
      if (vivo[i]) x_esq_min = pos_x[i];
    end
    na_borda = dir ? ((x_dir_max + LARG + PX) > XM) : (x_esq_min < PX);
  end

  assign xb       = {1'b0, x_bola_aliada};
  assign yb       = {1'b0, y_bola_aliada};
  assign linha_ok = (yb >= base_y) && (yb < base_y + ALT);

  // At most one kill per cycle: the lowest index among the hit enemies.
  always_comb begin
    atingido = '0;
    for (int i = 0; i < N_INIMIGOS; i++) begin
      atingido[i] = vivo[i] && linha_ok &&
                    (xb >= pos_x[i]) && (xb < pos_x[i] + LARG);
    end
    if (!(bola_aliada_ativa && (estado == MOVENDO))) atingido = '0;
    mata     = 1'b0;
    mata_idx = '0;
    for (int i = N_INIMIGOS - 1; i >= 0; i--) begin
      if (atingido[i]) begin
        mata     = 1'b1;
        mata_idx = 3'(i);
      end
    end
  end

  // A step and a kill in the same cycle both apply; the edge decision above
  // was taken from the pre-kill vivo.
  always_comb begin
    base_x_prox = base_x;
    base_y_prox = base_y;
    dir_prox    = dir;
    vivo_prox   = vivo;
    if (tick) begin
      if (na_borda) begin
        base_y_prox = base_y + PY;
        dir_prox    = ~dir;
      end else if (dir) begin
        base_x_prox = base_x + PX;
      end else begin
        base_x_prox = base_x - PX;
      end
    end
    if (mata) vivo_prox[mata_idx] = 1'b0;
  end

  // Outputs are built from the next-state values so they move on the same
  // edge as the internal state.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      base_x             <= XI;
      base_y             <= YI;
      dir                <= 1'b1;
      vivo               <= '1;
      inimigo_x          <= empacota_x(XI, ESPACO);
      inimigo_y          <= empacota_y(YI);
      inimigo_vivo_array <= '1;
      acerto             <= 1'b0;
      indice_acerto      <= '0;
      todos_mortos       <= 1'b0;
      chegou_base        <= 1'b0;
    end else begin
      base_x       <= base_x_prox;
      base_y       <= base_y_prox;
      dir          <= dir_prox;
      vivo         <= vivo_prox;
      inimigo_x    <= empacota_x(base_x_prox, ESPACO);
      inimigo_y    <= empacota_y(base_y_prox);
      for (int i = 0; i < N_INIMIGOS; i++) begin
        inimigo_vivo_array[i] <= vivo_prox[i];
      end
      acerto       <= mata;
      if (mata) indice_acerto <= mata_idx;
      todos_mortos <= (vivo_prox == '0);
      chegou_base  <= (base_y_prox >= YL);
    end
  end

endmodule

// File: tb/tb_formacao_inimigos.sv
// tb_formacao_inimigos: directed bench for formacao_inimigos.
// Stimulus pushes expected formation moves and kills into queues; a monitor
// on the falling clock edge pops them whenever the DUT moves or pulses acerto.
module tb_formacao_inimigos;

  localparam int TD = 4;

  typedef struct packed {
    logic [49:0] x;
    logic [49:0] y;
  } pos_t;

  typedef struct packed {
    logic [2:0] idx;
    logic [4:0] vivo;
    logic       todos;
  } kill_t;

  logic        CLOCK_50 = 1'b0;
  logic        reset    = 1'b1;
  logic        ativo    = 1'b0;
  logic        bola     = 1'b0;
  logic [9:0]  xb       = '0;
  logic [9:0]  yb       = '0;
  logic [49:0] inimigo_x;
  logic [49:0] inimigo_y;
  logic [0:4]  vivo_arr;
  logic        acerto;
  logic [2:0]  indice_acerto;
  logic        todos_mortos;
  logic        chegou_base;
  logic [4:0]  vivo;

  int n_cmp  = 0;
  int n_fail = 0;
  int acertos = 0;

  pos_t  pos_q[$];
  kill_t kill_q[$];

  int         m_bx;
  int         m_by;
  bit         m_dir;
  logic [4:0] m_vivo;

  assign vivo = {vivo_arr[4], vivo_arr[3], vivo_arr[2], vivo_arr[1], vivo_arr[0]};

  formacao_inimigos #(
    .TICK_DIV (TD),
    .Y_LIMITE (72)
  ) dut (
    .CLOCK_50           (CLOCK_50),
    .reset              (reset),
    .ativo              (ativo),
    .x_bola_aliada      (xb),
    .y_bola_aliada      (yb),
    .bola_aliada_ativa  (bola),
    .inimigo_x          (inimigo_x),
    .inimigo_y          (inimigo_y),
    .inimigo_vivo_array (vivo_arr),
    .acerto             (acerto),
    .indice_acerto      (indice_acerto),
    .todos_mortos       (todos_mortos),
    .chegou_base        (chegou_base)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  function automatic logic [49:0] exp_x(input int bx);
    logic [49:0] r;
    for (int i = 0; i < 5; i++) r[10*i +: 10] = 10'(bx + 80 * i);
    return r;
  endfunction

  function automatic logic [49:0] exp_y(input int by);
    logic [9:0] v;
    v = 10'(by);
    return {5{v}};
  endfunction

  task automatic checkOutput(input string nome, input logic [63:0] atual,
                             input logic [63:0] esperado);
    n_cmp++;
    if (atual !== esperado) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
               nome, atual, atual, esperado, esperado);
    end
  endtask

  task automatic applyStimulus(input logic a, input logic b,
                               input int x, input int y);
    ativo = a;
    bola  = b;
    xb    = 10'(x);
    yb    = 10'(y);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  // Expected result of the next n movement steps, from the formation rules.
  task automatic push_moves(input int n);
    for (int k = 0; k < n; k++) begin
      int   xr;
      int   xl;
      bit   borda;
      pos_t p;
      xr = -1;
      xl = -1;
      for (int i = 0; i < 5; i++) begin
        if (m_vivo[i]) begin
          if (xl < 0) xl = m_bx + 80 * i;
          xr = m_bx + 80 * i;
        end
      end
      borda = m_dir ? (xr + 33 + 4 > 640) : (xl < 4);
      if (borda) begin
        m_by  = m_by + 16;
        m_dir = !m_dir;
      end else if (m_dir) begin
        m_bx = m_bx + 4;
      end else begin
        m_bx = m_bx - 4;
      end
      p.x = exp_x(m_bx);
      p.y = exp_y(m_by);
      pos_q.push_back(p);
    end
  endtask

  task automatic push_kill(input int idx, input logic [4:0] v, input logic t);
    kill_t k;
    k.idx   = 3'(idx);
    k.vivo  = v;
    k.todos = t;
    kill_q.push_back(k);
  endtask

  task automatic clear_model;
    pos_q.delete();
    kill_q.delete();
    m_bx   = 40;
    m_by   = 40;
    m_dir  = 1'b1;
    m_vivo = 5'b11111;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 0, 0);
    clear_model();
    cycles(2);
    reset = 1'b0;
    cycles(1);
  endtask

  logic [49:0] prev_x;
  logic [49:0] prev_y;
  pos_t        mon_p;
  kill_t       mon_k;

  always @(negedge CLOCK_50) begin
    if (reset) begin
      prev_x = inimigo_x;
      prev_y = inimigo_y;
    end else begin
      if (inimigo_x !== prev_x || inimigo_y !== prev_y) begin
        if (pos_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("[TB] FAIL move_unexpected: got x0=%0d y=%0d, expected no move",
                   inimigo_x[9:0], inimigo_y[9:0]);
        end else begin
          mon_p = pos_q.pop_front();
          checkOutput("move_x", inimigo_x, mon_p.x);
          checkOutput("move_y", inimigo_y, mon_p.y);
        end
        prev_x = inimigo_x;
        prev_y = inimigo_y;
      end
      if (acerto) begin
        acertos++;
        if (kill_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("[TB] FAIL kill_unexpected: got acerto idx=%0d, expected none",
                   indice_acerto);
        end else begin
          mon_k = kill_q.pop_front();
          checkOutput("kill_idx", indice_acerto, mon_k.idx);
          checkOutput("kill_vivo", vivo, mon_k.vivo);
          checkOutput("kill_todos", todos_mortos, mon_k.todos);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int a0;
    int n;

    // Reset values
    do_reset();
    checkOutput("rst_x0", inimigo_x[9:0], 40);
    checkOutput("rst_x4", inimigo_x[49:40], 360);
    checkOutput("rst_y", inimigo_y, exp_y(40));
    checkOutput("rst_vivo", vivo, 5'b11111);
    checkOutput("rst_acerto", acerto, 0);
    checkOutput("rst_indice", indice_acerto, 0);
    checkOutput("rst_todos", todos_mortos, 0);
    checkOutput("rst_base", chegou_base, 0);

    // March right, first step TICK_DIV cycles into MOVENDO
    push_moves(2);
    applyStimulus(1'b1, 1'b0, 0, 0);
    cycles(4);
    checkOutput("march_x0_4", inimigo_x[9:0], 40);
    cycles(4);
    checkOutput("march_x0_8", inimigo_x[9:0], 44);
    cycles(4);
    checkOutput("march_x0_12", inimigo_x[9:0], 48);
    checkOutput("march_x4_12", inimigo_x[49:40], 368);
    checkOutput("march_y_12", inimigo_y[9:0], 40);

    // Right edge: x holds, drop to 56, then head left
    push_moves(60);
    cycles(240);
    checkOutput("edge_x0", inimigo_x[9:0], 284);
    checkOutput("edge_y", inimigo_y[9:0], 56);
    push_moves(1);
    cycles(4);
    checkOutput("left_x0", inimigo_x[9:0], 280);
    checkOutput("edge_q_empty", pos_q.size(), 0);

    // Kill enemy 4, then the turn follows enemy 3
    do_reset();
    push_kill(4, 5'b01111, 1'b0);
    m_vivo = 5'b01111;
    push_moves(82);
    applyStimulus(1'b1, 1'b0, 0, 0);
    cycles(1);
    applyStimulus(1'b1, 1'b1, 370, 50);
    cycles(1);
    applyStimulus(1'b1, 1'b0, 0, 0);
    cycles(330);
    checkOutput("k4_edge_x0", inimigo_x[9:0], 364);
    checkOutput("k4_edge_x3", inimigo_x[39:30], 604);
    checkOutput("k4_edge_y", inimigo_y[9:0], 56);
    checkOutput("k4_vivo", vivo, 5'b01111);
    checkOutput("k4_q_empty", pos_q.size() + kill_q.size(), 0);

    // Kill all five, single pulse while the shot is held
    do_reset();
    push_moves(2);
    push_kill(0, 5'b11110, 1'b0);
    push_kill(1, 5'b11100, 1'b0);
    push_kill(2, 5'b11000, 1'b0);
    push_kill(3, 5'b10000, 1'b0);
    push_kill(4, 5'b00000, 1'b1);
    a0 = acertos;
    applyStimulus(1'b1, 1'b0, 0, 0);
    cycles(1);
    applyStimulus(1'b1, 1'b1, 45, 50);
    cycles(3);
    checkOutput("hold_pulses", acertos - a0, 1);
    checkOutput("hold_vivo", vivo, 5'b11110);
    checkOutput("hold_indice", indice_acerto, 0);
    applyStimulus(1'b1, 1'b1, 130, 45);
    cycles(1);
    checkOutput("e1_indice", indice_acerto, 1);
    applyStimulus(1'b1, 1'b1, 210, 45);
    cycles(1);
    applyStimulus(1'b1, 1'b1, 290, 45);
    cycles(1);
    applyStimulus(1'b1, 1'b1, 370, 45);
    cycles(1);
    applyStimulus(1'b1, 1'b0, 0, 0);
    checkOutput("all_todos", todos_mortos, 1);
    checkOutput("all_acerto", acerto, 1);
    cycles(40);
    checkOutput("fim_x0", inimigo_x[9:0], 48);
    checkOutput("fim_pulses", acertos - a0, 5);
    checkOutput("fim_q_empty", pos_q.size() + kill_q.size(), 0);

    // Drop ativo: positions hold, divider restarts from zero
    do_reset();
    push_moves(2);
    applyStimulus(1'b1, 1'b0, 0, 0);
    cycles(10);
    applyStimulus(1'b0, 1'b0, 0, 0);
    cycles(20);
    checkOutput("pause_x0", inimigo_x[9:0], 48);
    checkOutput("pause_q_empty", pos_q.size(), 0);
    push_moves(1);
    applyStimulus(1'b1, 1'b0, 0, 0);
    cycles(4);
    checkOutput("resume_x0_4", inimigo_x[9:0], 48);
    cycles(1);
    checkOutput("resume_x0_5", inimigo_x[9:0], 52);

    // Kill enemy 2, then reset asynchronously mid-cycle
    push_kill(2, 5'b11011, 1'b0);
    applyStimulus(1'b1, 1'b1, 220, 45);
    cycles(1);
    applyStimulus(1'b1, 1'b0, 0, 0);
    cycles(1);
    checkOutput("pre_rst_vivo", vivo, 5'b11011);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("async_rst_x", inimigo_x, exp_x(40));
    checkOutput("async_rst_y", inimigo_y[9:0], 40);
    checkOutput("async_rst_vivo", vivo, 5'b11111);
    checkOutput("async_rst_indice", indice_acerto, 0);
    clear_model();
    cycles(2);

    // Formation reaches the base after two drops (Y_LIMITE = 72)
    do_reset();
    n = 0;
    while (m_by < 72) begin
      push_moves(1);
      n++;
    end
    applyStimulus(1'b1, 1'b0, 0, 0);
    cycles(1 + TD * n + 4);
    checkOutput("base_flag", chegou_base, 1);
    checkOutput("base_y", inimigo_y[9:0], 72);
    checkOutput("base_x0", inimigo_x[9:0], 0);
    checkOutput("base_todos", todos_mortos, 0);
    checkOutput("base_q_empty", pos_q.size(), 0);
    cycles(40);
    checkOutput("frozen_x0", inimigo_x[9:0], 0);
    checkOutput("frozen_y", inimigo_y[9:0], 72);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/formacao_inimigos.md
# formacao_inimigos

Enemy-formation controller for the invader game, directly upstream of the screen renderer. Owns the positions and alive flags of the five enemies, marches the formation horizontally on a fixed step clock, drops it one row at each screen edge, and kills an enemy when the allied shot lands inside its box. Outputs are the packed coordinate buses and alive array the renderer draws from, plus hit/end-of-game flags for the game control logic.

## Interface

Parameters:
- TICK_DIV, 1_000_000 — CLOCK_50 cycles per movement step (20 ms).
- PASSO_X, 4 — horizontal step, pixels.
- PASSO_Y, 16 — vertical drop at an edge, pixels.
- X_INICIAL, 40 — initial x of enemy 0.
- Y_INICIAL, 40 — initial y of the formation.
- ESPACO, 80 — x pitch between adjacent enemies.
- X_MAX, 640 — right screen bound, exclusive.
- Y_LIMITE, 400 — formation y at or beyond which the enemies have reached the base.

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ativo  in  1  game running; low freezes the formation and the step divider.
- x_bola_aliada  in  10  allied shot x, game coordinates.
- y_bola_aliada  in  10  allied shot y, game coordinates.
- bola_aliada_ativa  in  1  allied shot is in flight.
- inimigo_x  out  50  enemy i x at [10i+9:10i], i = 0..4.
- inimigo_y  out  50  enemy i y at [10i+9:10i]; all five equal.
- inimigo_vivo_array  out  [0:4]  bit i high = enemy i alive.
- acerto  out  1  one-cycle pulse: an enemy was killed.
- indice_acerto  out  3  index of the killed enemy, valid while acerto is high.
- todos_mortos  out  1  level: no enemy alive.
- chegou_base  out  1  level: formation y >= Y_LIMITE.

## Operation

- Enemy box: LARGURA = 33, ALTURA = 24 (11x8 sprite at 3x).
- Internal state: base_x (x of enemy 0), base_y, dir (1 = right), vivo[4:0]. Enemy i x = base_x + i*ESPACO.
- FSM states: PARADO, MOVENDO, FIM.
- PARADO -> MOVENDO when ativo is high.
- MOVENDO -> PARADO when ativo is low.
- MOVENDO -> FIM when todos_mortos or chegou_base is high.
- FIM is held until reset.
- Step: in MOVENDO, a tick fires when the divider reaches TICK_DIV-1. The divider wraps to 0 and is held at 0 outside MOVENDO.
- On a tick, edge case: if dir = 1 and (x of the rightmost alive enemy) + LARGURA + PASSO_X > X_MAX, or dir = 0 and (x of the leftmost alive enemy) < PASSO_X:
  - base_y += PASSO_Y and dir flips;
  - base_x is unchanged on that tick.
- On a tick otherwise: base_x += PASSO_X when dir = 1, and base_x -= PASSO_X when dir = 0.
- Edge checks use only alive enemies. Positions are computed at 11 bits so nothing wraps.
- Collision is checked every cycle in MOVENDO while bola_aliada_ativa is high. Enemy i is hit when vivo[i] is high and ex <= xb < ex+33 and ey <= yb < ey+24. Compares are 11-bit.
- On a collision, only the lowest-index hit enemy is killed that cycle. It is cleared from vivo, acerto pulses and indice_acerto gets that index.
- Kill and tick in the same cycle: both apply. The edge check uses the pre-kill vivo.
- No collisions in PARADO or FIM; acerto stays low.

## Timing

- All outputs are registered and update one cycle after the causing event.
- Reset values:
  - base_x = X_INICIAL, base_y = Y_INICIAL, dir = 1, vivo = 5'b11111.
  - inimigo_x / inimigo_y reflect those positions, i.e. enemy i at (40+80i, 40).
  - acerto = 0, indice_acerto = 0, todos_mortos = 0, chegou_base = 0.
  - FSM in PARADO, divider = 0.
- First tick comes TICK_DIV cycles after entering MOVENDO.
- A kill of the last enemy raises todos_mortos in the same cycle as acerto. FSM reaches FIM the cycle after.
- Reset mid-game restores all reset values immediately and asynchronously.

## Structure

- Shared package `jogo_pkg`:
  - COORD_W = 10, N_INIMIGOS = 5;
  - LARGURA_INIMIGO = 33, ALTURA_INIMIGO = 24;
  - FSM state encoding.
  The renderer and shot blocks use the same package.
- One sub-module: `divisor_tick` (parameter TICK_DIV; ports CLOCK_50, reset, habilita, tick).
- Collision and leftmost/rightmost-alive logic stay combinational inside the block.

## Test plan

- Reset, ativo = 1, TICK_DIV = 4:
  - enemy 0 x = 40, 44, 48 after 4, 8, 12 cycles;
  - y stays 40;
  - enemy 4 x = base_x + 320.
- Run to the right edge. The tick with enemy 4 x + 37 > 640 leaves x unchanged, sets y = 56 and flips dir. The next tick decrements x by 4.
- Kill enemy 4, then run right. The edge turn now follows enemy 3, about 80 px further right than the previous turn.
- Shot at (45, 50) with bola_aliada_ativa = 1 at reset positions: acerto pulses once, indice_acerto = 0, vivo = 5'b11110. Holding the shot there gives no second pulse.
- Shot at (130, 45), overlapping enemy 1 only: indice_acerto = 1. Kill all five in turn: todos_mortos rises with the fifth acerto, FSM reaches FIM, and further ticks do not move the formation.
- Drive Y_LIMITE = 72 with PASSO_Y = 16: after two drops (y = 72), chegou_base = 1 and the formation freezes. Drop ativo mid-run: positions hold and the divider resets. Assert reset mid-run: reset values are restored.
